// File: rtl/arc4_sched.sv
// arc4_sched: ARC4 S-box scheduler with selectable init / KSA passes.
// Owns the single port of the S memory while busy. A caller starts it with
// one en pulse while rdy is high, then waits for rdy/done to come back.
module arc4_sched #(
    parameter int KEY_BYTES = 3,
    parameter int AW        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [1:0]             mode,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [AW-1:0]          addr,
    input  logic [AW-1:0]          rddata,
    output logic [AW-1:0]          wrdata,
    output logic                   wren,
    output logic                   done
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [AW-1:0]          i;
    logic [AW-1:0]          j;
    logic [AW-1:0]          si;
    logic [AW-1:0]          sj;
    logic [AW-1:0]          addr_q;
    logic [AW-1:0]          wrdata_q;
    logic [KW-1:0]          kidx;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [1:0]             mode_q;
    logic [7:0]             key_byte;
    logic [AW-1:0]          j_next;
    logic                   i_last;
    logic                   finish;
    logic                   ksa_after_init;

    assign i_last         = &i;
    assign ksa_after_init = (mode_q != 2'b01);
    assign rdy            = (state == IDLE);

    // Select the current key byte; byte 0 sits in the most significant position.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KW'(k)) begin
                key_byte = key_q[8*(KEY_BYTES-k)-1 -: 8];
            end
        end
        j_next = j + rddata + AW'(key_byte);
    end

    // State register; reset returns to IDLE at any time, even mid-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory port drive; addr/wrdata hold their last value when unused.
    always_comb begin
        state_nxt = state;
        addr      = addr_q;
        wrdata    = wrdata_q;
        wren      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = (mode == 2'b10) ? RD_I : INIT;
                end
            end
            INIT: begin
                wren   = 1'b1;
                addr   = i;
                wrdata = i;
                if (i_last) begin
                    if (ksa_after_init) begin
                        state_nxt = RD_I;
                    end else begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            RD_I: begin
                addr      = i;
                state_nxt = LAT_I;
            end
            LAT_I: begin
                state_nxt = RD_J;
            end
            RD_J: begin
                addr      = j;
                state_nxt = LAT_J;
            end
            LAT_J: begin
                state_nxt = WR_I;
            end
            WR_I: begin
                wren      = 1'b1;
                addr      = i;
                wrdata    = sj;
                state_nxt = WR_J;
            end
            WR_J: begin
                wren   = 1'b1;
                addr   = j;
                wrdata = si;
                if (i_last) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = RD_I;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: counters, captured request, swap operands, held port values, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i        <= '0;
            j        <= '0;
            si       <= '0;
            sj       <= '0;
            kidx     <= '0;
            key_q    <= '0;
            mode_q   <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            done     <= 1'b0;
        end else begin
            addr_q   <= addr;
            wrdata_q <= wrdata;
            done     <= finish;
            case (state)
                IDLE: begin
                    if (en) begin
                        key_q  <= key;
                        mode_q <= mode;
                        i      <= '0;
                        j      <= '0;
                        kidx   <= '0;
                    end
                end
                INIT: begin
                    i <= i + AW'(1);
                    if (i_last) begin
                        j    <= '0;
                        kidx <= '0;
                    end
                end
                LAT_I: begin
                    si <= rddata;
                    j  <= j_next;
                end
                LAT_J: begin
                    sj <= rddata;
                end
                WR_J: begin
                    i    <= i + AW'(1);
                    kidx <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_sched.sv
// tb_arc4_sched: drives a default instance (AW=8, 3 key bytes) and a tiny
// instance (AW=2, 1 key byte), each with its own synchronous memory, and
// compares the memory contents and port timing against a software ARC4 model.
module tb_arc4_sched;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_en, a_rdy, a_wren, a_done;
    logic [1:0] a_mode;
    logic [23:0] a_key;
    logic [7:0] a_addr, a_rddata, a_wrdata;
    logic [7:0] a_mem [256];

    logic       b_en, b_rdy, b_wren, b_done;
    logic [1:0] b_mode;
    logic [7:0] b_key;
    logic [1:0] b_addr, b_rddata, b_wrdata;
    logic [1:0] b_mem [4];

    int vectors     = 0;
    int miscompares = 0;
    int ref_s [256];

    always #5 clk = ~clk;

    arc4_sched #(.KEY_BYTES(3), .AW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .rdy(a_rdy), .mode(a_mode),
        .key(a_key), .addr(a_addr), .rddata(a_rddata), .wrdata(a_wrdata),
        .wren(a_wren), .done(a_done)
    );

    arc4_sched #(.KEY_BYTES(1), .AW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .rdy(b_rdy), .mode(b_mode),
        .key(b_key), .addr(b_addr), .rddata(b_rddata), .wrdata(b_wrdata),
        .wren(b_wren), .done(b_done)
    );

    // Synchronous single-port memory with registered address for each instance.
    always @(posedge clk) begin
        if (a_wren === 1'b1) a_mem[a_addr] <= a_wrdata;
        a_rddata <= a_mem[a_addr];
        if (b_wren === 1'b1) b_mem[b_addr] <= b_wrdata;
        b_rddata <= b_mem[b_addr];
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_init();
        for (int x = 0; x < 256; x++) ref_s[x] = x;
    endtask

    task automatic ref_ksa(input logic [23:0] k);
        int jj;
        int t;
        int kb [3];
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + ref_s[ii] + kb[ii % 3]) % 256;
            t = ref_s[ii];
            ref_s[ii] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    task automatic check_mem_a(input string tag);
        for (int x = 0; x < 256; x++) begin
            check_output($sformatf("%s S[%0d]", tag, x), 32'(a_mem[x]), 32'(ref_s[x]));
        end
    endtask

    // One run on instance A: pulse en, scramble inputs while busy, check timing and S.
    task automatic apply_stimulus(input logic [1:0] m, input logic [23:0] k,
                                  input int exp_n, input bit trace);
        int n;
        check_output("rdy_before_start", 32'(a_rdy), 32'd1);
        a_mode = m;
        a_key  = k;
        a_en   = 1'b1;
        step();
        n = 0;
        while (a_rdy !== 1'b1 && n < 3000) begin
            if (trace && n < 256) begin
                check_output($sformatf("init_wren[%0d]", n), 32'(a_wren), 32'd1);
                check_output($sformatf("init_addr[%0d]", n), 32'(a_addr), 32'(n));
                check_output($sformatf("init_wrdata[%0d]", n), 32'(a_wrdata), 32'(n));
            end
            a_en   = (n < exp_n - 2) ? 1'($urandom) : 1'b0;
            a_key  = 24'($urandom);
            a_mode = 2'($urandom);
            step();
            n++;
        end
        a_en = 1'b0;
        check_output($sformatf("busy_cycles mode=%0d", m), 32'(n), 32'(exp_n));
        check_output("done_with_rdy", 32'(a_done), 32'd1);
        check_output("wren_idle", 32'(a_wren), 32'd0);
        if (m != 2'b10) ref_init();
        if (m != 2'b01) ref_ksa(k);
        step();
        check_output("done_one_cycle", 32'(a_done), 32'd0);
        check_output("rdy_stays", 32'(a_rdy), 32'd1);
        check_mem_a($sformatf("mode=%0d key=%06h", m, k));
    endtask

    initial begin
        int n;
        int s4 [4];
        int jj;
        int t;
        int exp_b [4];
        logic [3:0] wlog [$];
        logic [3:0] elog [$];

        rst_n  = 1'b0;
        a_en   = 1'b0;
        a_mode = 2'b00;
        a_key  = '0;
        b_en   = 1'b0;
        b_mode = 2'b00;
        b_key  = '0;
        #3;
        check_output("reset_rdy", 32'(a_rdy), 32'd1);
        check_output("reset_done", 32'(a_done), 32'd0);
        check_output("reset_wren", 32'(a_wren), 32'd0);
        check_output("reset_addr", 32'(a_addr), 32'd0);
        check_output("reset_wrdata", 32'(a_wrdata), 32'd0);
        check_output("reset_rdy_b", 32'(b_rdy), 32'd1);
        #4 rst_n = 1'b1;
        step();

        // Init only, with the write trace checked cycle by cycle.
        apply_stimulus(2'b01, 24'($urandom), 256, 1'b1);

        // Tiny instance: AW=2, key 01, init+KSA, full write log.
        b_key  = 8'h01;
        b_mode = 2'b00;
        b_en   = 1'b1;
        step();
        b_en = 1'b0;
        n = 0;
        while (b_rdy !== 1'b1 && n < 100) begin
            if (b_wren === 1'b1) wlog.push_back({b_addr, b_wrdata});
            b_key = 8'($urandom);
            step();
            n++;
        end
        check_output("b_busy_cycles", 32'(n), 32'd28);
        check_output("b_done", 32'(b_done), 32'd1);
        for (int x = 0; x < 4; x++) begin
            s4[x] = x;
            elog.push_back({2'(x), 2'(x)});
        end
        jj = 0;
        for (int ii = 0; ii < 4; ii++) begin
            jj = (jj + s4[ii] + 1) % 4;
            elog.push_back({2'(ii), 2'(s4[jj])});
            elog.push_back({2'(jj), 2'(s4[ii])});
            t = s4[ii];
            s4[ii] = s4[jj];
            s4[jj] = t;
        end
        check_output("b_write_count", 32'(wlog.size()), 32'(elog.size()));
        for (int x = 0; x < elog.size() && x < wlog.size(); x++) begin
            check_output($sformatf("b_write[%0d]", x), 32'(wlog[x]), 32'(elog[x]));
        end
        exp_b = '{0, 2, 3, 1};
        for (int x = 0; x < 4; x++) begin
            check_output($sformatf("b_S[%0d]", x), 32'(b_mem[x]), 32'(exp_b[x]));
            check_output($sformatf("b_S_model[%0d]", x), 32'(b_mem[x]), 32'(s4[x]));
        end

        // Full init+KSA with the reference key, then mode 11 aliasing mode 00.
        apply_stimulus(2'b00, 24'h00033C, 1792, 1'b0);
        apply_stimulus(2'b11, 24'h000001, 1792, 1'b0);

        // KSA only on a freshly initialised table.
        apply_stimulus(2'b01, 24'($urandom), 256, 1'b0);
        apply_stimulus(2'b10, 24'h000001, 1536, 1'b0);

        // en held high: one run per rdy window, restart in the done cycle.
        a_mode = 2'b01;
        a_key  = 24'($urandom);
        a_en   = 1'b1;
        step();
        n = 0;
        while (a_rdy !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        check_output("held_en_run1_cycles", 32'(n), 32'd256);
        check_output("held_en_run1_done", 32'(a_done), 32'd1);
        step();
        check_output("held_en_restart", 32'(a_rdy), 32'd0);
        n = 0;
        while (a_rdy !== 1'b1 && n < 3000) begin
            if (n == 100) a_en = 1'b0;
            step();
            n++;
        end
        check_output("held_en_run2_cycles", 32'(n), 32'd256);
        check_output("held_en_run2_done", 32'(a_done), 32'd1);
        step();
        check_output("no_restart_after_drop", 32'(a_rdy), 32'd1);

        // Asynchronous reset in the middle of KSA, then a clean rerun.
        a_mode = 2'b00;
        a_key  = 24'($urandom);
        a_en   = 1'b1;
        step();
        a_en = 1'b0;
        repeat (699) step();
        check_output("pre_reset_wren", 32'(a_wren), 32'd1);
        check_output("pre_reset_rdy", 32'(a_rdy), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_wren", 32'(a_wren), 32'd0);
        check_output("async_reset_rdy", 32'(a_rdy), 32'd1);
        check_output("async_reset_done", 32'(a_done), 32'd0);
        check_output("async_reset_addr", 32'(a_addr), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check_output("post_reset_idle", 32'(a_rdy), 32'd1);
        apply_stimulus(2'b00, 24'($urandom), 1792, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Parametrised S-box scheduler. Merges the separate init and KSA passes into one engine with selectable mode, generic key length and generic S-memory depth.
- Owns the single port of the S memory during operation.
- Top-level sequencers start it with one en pulse and wait for rdy.
- Key length and table size are parameters, so the same block serves the 24-bit-key cracker and longer-key variants.

Parameters:
- KEY_BYTES, 3, number of key bytes; legal range 1..32.
- AW, 8, S address and data width; LEN = 2**AW entries; all index/value arithmetic is modulo LEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high = idle and able to accept en
- mode  in  2  00 init+KSA, 01 init only, 10 KSA only, 11 treated as 00; captured with en
- key  in  8*KEY_BYTES  key; byte k = key[8*(KEY_BYTES-k)-1 -: 8] (byte 0 is most significant); captured with en
- addr  out  AW  S memory address
- rddata  in  AW  S memory read data
- wrdata  out  AW  S memory write data
- wren  out  1  S memory write enable
- done  out  1  one-cycle pulse on completion

Behaviour:
- Memory model: synchronous single port with registered address. Data for the address presented in cycle t appears on rddata in cycle t+1. A write and a read are never issued in the same cycle.
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - rdy=1, done=0, wren=0, addr=0, wrdata=0.
  - Internal i, j and captured key/mode are cleared.
  - Memory contents are left partially updated; the caller must restart.
- Handshake:
  - en=1 with rdy=1 at an edge latches key and mode; rdy=0 from the next cycle.
  - en while rdy=0 is ignored.
  - On completion rdy=1 and done=1 in the same cycle. done stays high for exactly one cycle.
  - en in that cycle starts a new run.
- States: IDLE, INIT, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J.
- INIT:
  - Each cycle: wren=1, addr=i, wrdata=i, then i++.
  - After i=LEN-1: if mode includes KSA, go to RD_I with i=0, j=0; otherwise go to IDLE.
  - Duration: LEN cycles.
- KSA, 6 cycles per i:
  - RD_I: addr=i.
  - LAT_I: si<=rddata; j<=(j+rddata+keybyte[i mod KEY_BYTES]) truncated to AW bits.
  - RD_J: addr=j.
  - LAT_J: sj<=rddata.
  - WR_I: wren=1, addr=i, wrdata=sj.
  - WR_J: wren=1, addr=j, wrdata=si; then i++. Go to RD_I, or to IDLE after i=LEN-1.
- i==j: both writes are issued; the value is unchanged.
- Key index counter: separate modulo-KEY_BYTES counter, reset to 0 at KSA start (no divider).
- wren=0 in every non-write state. addr/wrdata hold their last value when unused.
- Busy durations (en accepted at edge 0; rdy high in cycle N+1):
  - init only: N=LEN.
  - KSA only: N=6*LEN.
  - init+KSA: N=7*LEN (1792 at AW=8).
- mode and key changes during busy have no effect.

Test Plan:
- Reset, AW=8, mode=01, en pulse:
  - Expect wren high for 256 consecutive cycles with addr=wrdata=0..255.
  - rdy=1 and done=1 in cycle 257.
  - Memory S[k]=k.
- AW=2, KEY_BYTES=1, key=8'h01, mode=00:
  - Final S=[0,2,3,1].
  - rdy returns in cycle 29.
  - Write sequence after init: (0:1,1:0),(1:2,2:0),(2:3,3:0),(3:1,0:0).
- AW=8, KEY_BYTES=3, key=24'h00033C, mode=00:
  - Final 256-entry S matches the software ARC4 KSA model byte-for-byte.
  - Total busy 1792 cycles.
- en held high continuously:
  - Exactly one run per rdy window.
  - Back-to-back restart in the done cycle.
  - en while busy neither restarts the run nor alters key.
- Assert rst_n low in mid-KSA (cycle 700):
  - wren drops immediately (async); rdy=1 and done=0.
  - A new mode=00 run then produces a correct S.
- mode=11 with key=24'h000001:
  - Behaves identically to mode=00 (same S, 1792 cycles).
  - mode=10 on a pre-initialised S gives the same S in 1536 cycles.
